fft_sdf_butterfly: RTL and testbench

- Radix-2 single-path delay-feedback (SDF) butterfly stage for the 1-D 8-point FFT pipeline.
- Takes one complex sample per valid cycle and pairs sample k with sample k+DELAY through an internal delay line.
- Emits the scaled sum directly, then emits the twiddle-rotated difference one half-frame later.
- Consumes W_real/W_imag from the twiddle generator placed directly beside it in the stage.

---
 rtl/fft_sdf_butterfly_pkg.sv | 49 ++++
 rtl/fft_cmul_round.sv | 29 ++
 rtl/fft_sdf_butterfly.sv | 124 ++++++++++++
 tb/tb_fft_sdf_butterfly.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_sdf_butterfly_pkg.sv
// Shared widths, saturation limits, bus payload types and twiddle constants for the SDF stage.
package fft_sdf_butterfly_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned W_W    = 16;
  localparam int unsigned W_FRAC = 14;
  localparam int unsigned DELAY  = 4;
  localparam int unsigned SCALE  = 1;
  localparam int unsigned CNT_W  = $clog2(2 * DELAY);
  localparam int unsigned SUM_W  = DATA_W + 1;
  localparam int unsigned PROD_W = DATA_W + 1 + W_W + 1;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [W_W-1:0] re;
    logic signed [W_W-1:0] im;
  } twid_t;

  // exp(-j*2*pi*k/8) in Q1.14; W8/W9 repeat W0/W1 for generators that run past one turn
  localparam twid_t W0 = '{re:  16'sd16384, im:  16'sd0};
  localparam twid_t W1 = '{re:  16'sd11585, im: -16'sd11585};
  localparam twid_t W2 = '{re:  16'sd0,     im: -16'sd16384};
  localparam twid_t W3 = '{re: -16'sd11585, im: -16'sd11585};
  localparam twid_t W4 = '{re: -16'sd16384, im:  16'sd0};
  localparam twid_t W5 = '{re: -16'sd11585, im:  16'sd11585};
  localparam twid_t W6 = '{re:  16'sd0,     im:  16'sd16384};
  localparam twid_t W7 = '{re:  16'sd11585, im:  16'sd11585};
  localparam twid_t W8 = '{re:  16'sd16384, im:  16'sd0};
  localparam twid_t W9 = '{re:  16'sd11585, im: -16'sd11585};

  // Clamp a wide signed value into the data range
  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [PROD_W-1:0] x);
    if (x > PROD_W'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (x < PROD_W'(SAT_MIN)) begin
      return SAT_MIN;
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fft_cmul_round.sv
// Combinational complex multiply of the difference by the twiddle, round half-up, saturate.
module fft_cmul_round
  import fft_sdf_butterfly_pkg::*;
(
  input  logic signed [SUM_W-1:0] d_re_i,
  input  logic signed [SUM_W-1:0] d_im_i,
  input  logic signed [W_W-1:0]   w_re_i,
  input  logic signed [W_W-1:0]   w_im_i,
  output cplx_t                   prod_c
);

  localparam logic signed [PROD_W-1:0] RND = PROD_W'(2 ** (W_FRAC - 1));

  logic signed [PROD_W-1:0] pr_full;
  logic signed [PROD_W-1:0] pi_full;
  logic signed [PROD_W-1:0] pr_rnd;
  logic signed [PROD_W-1:0] pi_rnd;

  // Full-precision products, then round and rescale to data width
  always_comb begin
    pr_full   = PROD_W'(d_re_i) * PROD_W'(w_re_i) - PROD_W'(d_im_i) * PROD_W'(w_im_i);
    pi_full   = PROD_W'(d_re_i) * PROD_W'(w_im_i) + PROD_W'(d_im_i) * PROD_W'(w_re_i);
    pr_rnd    = (pr_full + RND) >>> W_FRAC;
    pi_rnd    = (pi_full + RND) >>> W_FRAC;
    prod_c.re = sat_data(pr_rnd);
    prod_c.im = sat_data(pi_rnd);
  end

endmodule

// File: rtl/fft_sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly: sums out in phase 1, rotated diffs out next phase 0.
module fft_sdf_butterfly
  import fft_sdf_butterfly_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_frame_start,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic signed [W_W-1:0]    W_real,
  input  logic signed [W_W-1:0]    W_imag,
  output logic                     out_valid,
  output logic                     out_frame_start,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic                     frame_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;
  cplx_t            dl_q [DELAY];
  cplx_t            dl_d [DELAY];
  cplx_t            out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_fs_q, out_fs_d;
  logic             frame_err_q, frame_err_d;

  cplx_t                   head;
  cplx_t                   prod_c;
  logic                    misalign;
  logic                    phase1;
  logic [CNT_W-1:0]        cnt_eff;
  logic signed [SUM_W-1:0] sum_re, sum_im, diff_re, diff_im;

  assign head = dl_q[0];

  fft_cmul_round u_cmul (
    .d_re_i (diff_re),
    .d_im_i (diff_im),
    .w_re_i (W_real),
    .w_im_i (W_imag),
    .prod_c (prod_c)
  );

  // Butterfly arithmetic, delay-line shift, phase counter and output selection
  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    dl_d        = dl_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_fs_d    = 1'b0;
    frame_err_d = 1'b0;

    // A frame start anywhere but index 0 restarts the frame at phase 0
    misalign = in_frame_start && (cnt_q != '0);
    cnt_eff  = misalign ? '0 : cnt_q;
    phase1   = cnt_eff >= CNT_W'(DELAY);

    sum_re  = (SUM_W'(head.re) + SUM_W'(in_real)) >>> SCALE;
    sum_im  = (SUM_W'(head.im) + SUM_W'(in_imag)) >>> SCALE;
    diff_re = (SUM_W'(head.re) - SUM_W'(in_real)) >>> SCALE;
    diff_im = (SUM_W'(head.im) - SUM_W'(in_imag)) >>> SCALE;

    if (in_valid) begin
      for (int i = 0; i < int'(DELAY) - 1; i++) begin
        dl_d[i] = dl_q[i+1];
      end
      cnt_d       = cnt_eff + CNT_W'(1);
      frame_err_d = misalign;
      if (misalign) begin
        primed_d = 1'b0;
      end

      if (phase1) begin
        dl_d[DELAY-1] = prod_c;
        out_d.re      = sat_data(PROD_W'(sum_re));
        out_d.im      = sat_data(PROD_W'(sum_im));
        out_valid_d   = 1'b1;
        out_fs_d      = (cnt_eff == CNT_W'(DELAY));
        if (cnt_eff == CNT_W'(2 * DELAY - 1)) begin
          primed_d = 1'b1;
        end
      end else begin
        dl_d[DELAY-1] = '{re: in_real, im: in_imag};
        out_d         = head;
        out_valid_d   = primed_q && !misalign;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_fs_q    <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < int'(DELAY); i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_fs_q    <= out_fs_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < int'(DELAY); i++) begin
        dl_q[i] <= dl_d[i];
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_frame_start = out_fs_q;
  assign out_real        = out_q.re;
  assign out_imag        = out_q.im;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_fft_sdf_butterfly.sv
// Directed scoreboard bench for the SDF butterfly stage.
module tb_fft_sdf_butterfly;
  import fft_sdf_butterfly_pkg::*;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_frame_start;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic signed [W_W-1:0]    W_real;
  logic signed [W_W-1:0]    W_imag;
  logic                     out_valid;
  logic                     out_frame_start;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic                     frame_err;

  typedef struct {
    int re;
    int im;
    bit fs;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   err_seen = 0;

  fft_sdf_butterfly dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_frame_start  (in_frame_start),
    .in_real         (in_real),
    .in_imag         (in_imag),
    .W_real          (W_real),
    .W_imag          (W_imag),
    .out_valid       (out_valid),
    .out_frame_start (out_frame_start),
    .out_real        (out_real),
    .out_imag        (out_imag),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input int re, input int im, input bit fs);
    exp_t e;
    e.re = re;
    e.im = im;
    e.fs = fs;
    sb.push_back(e);
  endtask

  task automatic send(input int re, input int im, input int wr, input int wi, input bit fs);
    @(negedge clk);
    in_valid       = 1'b1;
    in_frame_start = fs;
    in_real        = DATA_W'(re);
    in_imag        = DATA_W'(im);
    W_real         = W_W'(wr);
    W_imag         = W_W'(wi);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid       = 1'b0;
      in_frame_start = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (out_valid !== 1'b0 || out_frame_start !== 1'b0 || out_real !== '0 ||
        out_imag !== '0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL %s: got v=%b fs=%b re=%0d im=%0d err=%b, want all 0",
               tag, out_valid, out_frame_start, out_real, out_imag, frame_err);
    end
  endtask

  // Monitor: every valid output must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got (%0d,%0d) fs=%b with empty scoreboard",
                 out_real, out_imag, out_frame_start);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int'(out_real) != e.re || int'(out_imag) != e.im || out_frame_start !== e.fs) begin
          fails++;
          $display("FAIL out_sample: got (%0d,%0d) fs=%b, want (%0d,%0d) fs=%b",
                   out_real, out_imag, out_frame_start, e.re, e.im, e.fs);
        end
      end
    end
    if (rst_n && frame_err) begin
      err_seen++;
    end
  end

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_frame_start = 1'b0;
    in_real        = '0;
    in_imag        = '0;
    W_real         = '0;
    W_imag         = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_init");
    rst_n = 1'b1;

    // Frame A: first frame after reset, phase 0 suppressed
    send(100, 0, 0, 0, 1);
    send(200, 0, 0, 0, 0);
    send(300, 0, 0, 0, 0);
    send(400, 0, 0, 0, 0);
    expect_out(55, 0, 1);  send(10, 0, W0.re, W0.im, 0);
    expect_out(110, 0, 0); send(20, 0, W0.re, W0.im, 0);
    expect_out(165, 0, 0); send(30, 0, W0.re, W0.im, 0);
    expect_out(220, 0, 0); send(40, 0, W0.re, W0.im, 0);

    // Frame B: phase 0 emits A's diffs; phase 1 exercises -j, W1, saturation, -1 sum
    expect_out(45, 0, 0);  send(100, 0, 0, 0, 1);
    expect_out(90, 0, 0);  send(300, 0, 0, 0, 0);
    expect_out(135, 0, 0); send(32767, 32767, 0, 0, 0);
    expect_out(180, 0, 0); send(32767, 0, 0, 0, 0);
    expect_out(55, 0, 1);  send(10, 0, W2.re, W2.im, 0);
    expect_out(200, 0, 0); send(100, 0, W1.re, W1.im, 0);
    expect_out(0, 0, 0);   send(-32767, -32767, 16384, 16384, 0);
    expect_out(-1, 0, 0);  send(-32768, 0, W0.re, W0.im, 0);

    // Frame C: rotated diffs of B, then phase 1 with a 3-cycle stall
    expect_out(0, -45, 0);    send(100, 0, 0, 0, 1);
    expect_out(71, -71, 0);   send(200, 0, 0, 0, 0);
    expect_out(0, 32767, 0);  send(300, 0, 0, 0, 0);
    expect_out(32767, 0, 0);  send(400, 0, 0, 0, 0);
    expect_out(55, 0, 1);  send(10, 0, W0.re, W0.im, 0);
    expect_out(110, 0, 0); send(20, 0, W0.re, W0.im, 0);
    idle(3);
    expect_out(165, 0, 0); send(30, 0, W0.re, W0.im, 0);
    expect_out(220, 0, 0); send(40, 0, W0.re, W0.im, 0);

    // Frame D: C's diffs, one phase-1 sample, then a misaligned frame start at cnt=5
    expect_out(45, 0, 0);  send(1000, 0, 0, 0, 1);
    expect_out(90, 0, 0);  send(2000, 0, 0, 0, 0);
    expect_out(135, 0, 0); send(3000, 0, 0, 0, 0);
    expect_out(180, 0, 0); send(4000, 0, 0, 0, 0);
    expect_out(500, 0, 1); send(0, 0, W0.re, W0.im, 0);

    // Frame E: restarted by the misaligned start; phase 0 stays suppressed
    send(-100, 50, 0, 0, 1);
    send(40, -20, 0, 0, 0);
    send(7, 3, 0, 0, 0);
    send(0, 0, 0, 0, 0);
    expect_out(-40, 30, 1); send(20, 10, W0.re, W0.im, 0);
    expect_out(40, 0, 0);   send(40, 20, W0.re, W0.im, 0);
    expect_out(4, 1, 0);    send(1, -1, W0.re, W0.im, 0);
    expect_out(0, 0, 0);    send(0, 0, W0.re, W0.im, 0);

    // Frame F: E's diffs, then two phase-1 samples before a mid-frame reset
    expect_out(-60, 20, 0); send(0, 0, 0, 0, 1);
    expect_out(0, -20, 0);  send(0, 0, 0, 0, 0);
    expect_out(3, 2, 0);    send(0, 0, 0, 0, 0);
    expect_out(0, 0, 0);    send(0, 0, 0, 0, 0);
    expect_out(5, 10, 1);   send(10, 20, W0.re, W0.im, 0);
    expect_out(15, 20, 0);  send(30, 40, W0.re, W0.im, 0);
    idle(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid_frame");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;

    // Frame G: fresh after reset, phase 0 suppressed again
    send(100, 0, 0, 0, 1);
    send(200, 0, 0, 0, 0);
    send(300, 0, 0, 0, 0);
    send(400, 0, 0, 0, 0);
    expect_out(55, 0, 1);  send(10, 0, W0.re, W0.im, 0);
    expect_out(110, 0, 0); send(20, 0, W0.re, W0.im, 0);
    expect_out(165, 0, 0); send(30, 0, W0.re, W0.im, 0);
    expect_out(220, 0, 0); send(40, 0, W0.re, W0.im, 0);

    // Frame H: flush G's diffs
    expect_out(45, 0, 0);  send(0, 0, 0, 0, 1);
    expect_out(90, 0, 0);  send(0, 0, 0, 0, 0);
    expect_out(135, 0, 0); send(0, 0, 0, 0, 0);
    expect_out(180, 0, 0); send(0, 0, 0, 0, 0);
    idle(4);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    tests++;
    if (err_seen != 1) begin
      fails++;
      $display("FAIL frame_err_pulses: got %0d cycles high, want 1", err_seen);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
